// File: rtl/sma_out_capture.sv
// Output capture stage for the moving-average filter: blanks samples while the window refills,
// decimates settled samples and presents them downstream over a valid/ready handshake.
module sma_out_capture #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WSEL = 13,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_update_strobe,
  input  logic [31:0]       i_window_sel,
  input  logic [CNT_W-1:0]  i_decim,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_settled,
  output logic              o_overflow,
  output logic [CNT_W-1:0]  o_drop_cnt
);

  typedef enum logic {FILL, RUN} state_t;

  state_t           state, state_nx;
  logic [31:0]      wsel_reg, wsel_eff;
  logic [CNT_W:0]   fill_len, fill_cnt, fill_nx;
  logic [CNT_W-1:0] decim_cnt, decim_nx, decim_max;
  logic [CNT_W:0]   decim_inc;
  logic             win_change, capture;
  logic             transfer, load, drop;

  always_comb begin
    wsel_eff   = (wsel_reg > MAX_WSEL) ? MAX_WSEL : wsel_reg;
    fill_len   = (CNT_W+1)'(1) << wsel_eff;
    decim_max  = (i_decim == '0) ? CNT_W'(1) : i_decim;
    decim_inc  = {1'b0, decim_cnt} + (CNT_W+1)'(1);
    // Raw 32-bit compare: any change restarts the fill, even between clamped values.
    win_change = (i_window_sel != wsel_reg);
  end

  // Next-state: window change wins over a same-cycle strobe, which is then discarded.
  always_comb begin
    state_nx = state;
    fill_nx  = fill_cnt;
    decim_nx = decim_cnt;
    capture  = 1'b0;
    if (win_change) begin
      state_nx = FILL;
      fill_nx  = '0;
    end else if (i_update_strobe) begin
      case (state)
        FILL: begin
          fill_nx = fill_cnt + (CNT_W+1)'(1);
          if (fill_nx == fill_len) begin
            state_nx = RUN;
            decim_nx = '0;
          end
        end
        RUN: begin
          capture  = (decim_cnt == '0);
          decim_nx = (decim_inc >= {1'b0, decim_max}) ? '0 : decim_inc[CNT_W-1:0];
        end
        default: state_nx = FILL;
      endcase
    end
  end

  // Output decisions: a capture may reuse the slot being handed off in the same cycle.
  always_comb begin
    transfer = o_valid & i_ready;
    load     = capture & (~o_valid | i_ready);
    drop     = capture & o_valid & ~i_ready;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= FILL;
      fill_cnt   <= '0;
      decim_cnt  <= '0;
      wsel_reg   <= i_window_sel;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_settled  <= 1'b0;
      o_overflow <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      state     <= state_nx;
      fill_cnt  <= fill_nx;
      decim_cnt <= decim_nx;
      wsel_reg  <= i_window_sel;
      o_settled <= (state_nx == RUN);
      if (load) begin
        o_data  <= i_data;
        o_valid <= 1'b1;
      end else if (transfer) begin
        o_valid <= 1'b0;
      end
      if (drop) begin
        o_overflow <= 1'b1;
        if (o_drop_cnt != '1) o_drop_cnt <= o_drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sma_out_capture.sv
// Directed bench for sma_out_capture: fill blanking, window changes, decimation,
// backpressure drops and reset recovery, with hand-computed expectations.
module tb_sma_out_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic        strobe;
  logic [31:0] wsel;
  logic [15:0] decim;
  logic        ready;
  logic [31:0] o_data;
  logic        o_valid;
  logic        o_settled;
  logic        o_overflow;
  logic [15:0] o_drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sma_out_capture #(.DATA_W(32), .MAX_WSEL(13), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_update_strobe(strobe),
    .i_window_sel(wsel), .i_decim(decim), .i_ready(ready),
    .o_data(o_data), .o_valid(o_valid), .o_settled(o_settled),
    .o_overflow(o_overflow), .o_drop_cnt(o_drop_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input logic [31:0] d);
    strobe = 1'b1;
    data   = d;
    tick();
    strobe = 1'b0;
  endtask

  task automatic hold_strobe(input int n);
    strobe = 1'b1;
    data   = 32'hDEAD_BEEF;
    idle(n);
    strobe = 1'b0;
  endtask

  initial begin
    rst = 1'b1; data = '0; strobe = 1'b0; wsel = 32'd3; decim = 16'd1; ready = 1'b1;
    idle(2);
    rst = 1'b0;
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_settled", o_settled, 0);
    check("rst_overflow", o_overflow, 0);
    check("rst_drop", o_drop_cnt, 0);

    // wsel=3: eight blanked strobes, 90 clocks apart
    for (int s = 1; s <= 8; s++) begin
      pulse(32'(s));
      check("t1_fill_valid", o_valid, 0);
      if (s == 7) check("t1_settled_s7", o_settled, 0);
      if (s == 8) check("t1_settled_s8", o_settled, 1);
      idle(89);
    end
    pulse(32'h64);
    check("t1_cap_valid", o_valid, 1);
    check("t1_cap_data", o_data, 32'h64);
    tick();
    check("t1_xfer_clear", o_valid, 0);

    // window change between strobes
    wsel = 32'd12;
    tick();
    hold_strobe(4096);
    check("t2_run12", o_settled, 1);
    pulse(32'hAA);
    check("t2_aa_data", o_data, 32'hAA);
    idle(3);
    wsel = 32'd10;
    tick();
    check("t2_unsettle", o_settled, 0);
    hold_strobe(1024);
    check("t2_blank_valid", o_valid, 0);
    check("t2_resettled", o_settled, 1);
    pulse(32'hBB);
    check("t2_bb_valid", o_valid, 1);
    check("t2_bb_data", o_data, 32'hBB);
    idle(2);
    // window change on a strobe cycle: that strobe must not count
    wsel = 32'd11;
    pulse(32'hCC);
    check("t2_cc_valid", o_valid, 0);
    hold_strobe(2047);
    check("t2_2047_settled", o_settled, 0);
    hold_strobe(1);
    check("t2_2048_settled", o_settled, 1);
    pulse(32'hDD);
    check("t2_dd_data", o_data, 32'hDD);
    idle(1);

    // decimation by 4, then 0 behaving as 1
    decim = 16'd4;
    for (int i = 0; i < 12; i++) begin
      pulse(32'(i));
      check("t3_d4_valid", o_valid, (i % 4 == 0) ? 64'd1 : 64'd0);
      if (i % 4 == 0) check("t3_d4_data", o_data, 64'(i));
      tick();
    end
    decim = 16'd0;
    for (int i = 0; i < 4; i++) begin
      pulse(32'(100 + i));
      check("t3_d0_valid", o_valid, 1);
      check("t3_d0_data", o_data, 64'(100 + i));
      tick();
    end

    // backpressure: held sample, three drops, then simultaneous capture+transfer
    decim = 16'd1;
    ready = 1'b0;
    pulse(32'h111);
    check("t4_first", o_data, 32'h111);
    pulse(32'h222);
    pulse(32'h333);
    pulse(32'h444);
    check("t4_overflow", o_overflow, 1);
    check("t4_drop", o_drop_cnt, 3);
    check("t4_held_data", o_data, 32'h111);
    check("t4_held_valid", o_valid, 1);
    ready = 1'b1;
    pulse(32'h555);
    check("t4_swap_data", o_data, 32'h555);
    check("t4_swap_valid", o_valid, 1);
    check("t4_swap_drop", o_drop_cnt, 3);
    tick();
    check("t4_drain", o_valid, 0);

    // clamped window (2^13), pending sample survives a window change, reset mid-fill
    wsel = 32'd20;
    tick();
    hold_strobe(8191);
    check("t5_8191", o_settled, 0);
    hold_strobe(1);
    check("t5_8192", o_settled, 1);
    ready = 1'b0;
    pulse(32'h777);
    check("t5_pend", o_valid, 1);
    wsel = 32'd3;
    tick();
    check("t5_chg_settled", o_settled, 0);
    check("t5_chg_valid", o_valid, 1);
    check("t5_chg_data", o_data, 32'h777);
    hold_strobe(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ready = 1'b1;
    check("t5_rst_valid", o_valid, 0);
    check("t5_rst_data", o_data, 0);
    check("t5_rst_overflow", o_overflow, 0);
    check("t5_rst_drop", o_drop_cnt, 0);
    check("t5_rst_settled", o_settled, 0);
    hold_strobe(7);
    check("t5_refill7", o_settled, 0);
    hold_strobe(1);
    check("t5_refill8", o_settled, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
